// File: rtl/cam_stream_pkg.sv
// Shared types and constants for the camera-side test-pattern stream generator.
package cam_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_VSYNC,
        ST_VBP,
        ST_ACTIVE,
        ST_VFP
    } state_t;

    localparam logic [1:0] PAT_SOLID = 2'd0;
    localparam logic [1:0] PAT_GRAD  = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_MARCH = 2'd3;

    localparam int unsigned RGB_R_W = 5;
    localparam int unsigned RGB_G_W = 6;
    localparam int unsigned RGB_B_W = 5;
    localparam int unsigned PIX_W   = RGB_R_W + RGB_G_W + RGB_B_W;
    localparam int unsigned FRAME_W = 16;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cam_pixel_pattern.sv
// Combinational test-pattern generator: pixel coordinate and frame number to RGB565.
module cam_pixel_pattern
    import cam_stream_pkg::*;
#(
    parameter int unsigned X_W = 8,
    parameter int unsigned Y_W = 7
) (
    input  logic [X_W-1:0]     x,
    input  logic [Y_W-1:0]     y,
    input  logic [FRAME_W-1:0] frame,
    input  logic [1:0]         pattern,
    input  logic [PIX_W-1:0]   color,
    output logic [PIX_W-1:0]   pixel_c
);

    logic [PIX_W-1:0] xw;
    logic [PIX_W-1:0] yw;

    assign xw = PIX_W'(x);
    assign yw = PIX_W'(y);

    always_comb begin
        pixel_c = '0;
        case (pattern)
            PAT_SOLID: pixel_c = color;
            PAT_GRAD:  pixel_c = {xw[RGB_R_W-1:0], yw[RGB_G_W-1:0], frame[RGB_B_W-1:0]};
            PAT_CHECK: pixel_c = (xw[3] ^ yw[3]) ? '1 : '0;
            default:   pixel_c = xw + yw + PIX_W'(frame);
        endcase
    end

endmodule

// File: rtl/cam_stream_gen.sv
// OV7670-style frame transmitter (vsync/href/RGB565 bytes) paced by a byte-rate tick.
module cam_stream_gen
    import cam_stream_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = 160,
    parameter int unsigned H_BLANK     = 16,
    parameter int unsigned V_ACTIVE    = 120,
    parameter int unsigned VSYNC_LINES = 2,
    parameter int unsigned VBP_LINES   = 3,
    parameter int unsigned VFP_LINES   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick_i,
    input  logic               enable_i,
    input  logic [1:0]         pattern_sel_i,
    input  logic [PIX_W-1:0]   color_i,
    output logic               vsync_o,
    output logic               href_o,
    output logic [7:0]         data_o,
    output logic               de_o,
    output logic [FRAME_W-1:0] frame_cnt_o,
    output logic               busy_o
);

    localparam int unsigned HREF_TICKS = 2 * H_ACTIVE;
    localparam int unsigned LINE_TICKS = HREF_TICKS + H_BLANK;
    localparam int unsigned MAX_A      = (VSYNC_LINES > VBP_LINES) ? VSYNC_LINES : VBP_LINES;
    localparam int unsigned MAX_B      = (V_ACTIVE > VFP_LINES) ? V_ACTIVE : VFP_LINES;
    localparam int unsigned MAX_LINES  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned T_W        = cnt_w(LINE_TICKS);
    localparam int unsigned L_W        = cnt_w(MAX_LINES);
    localparam int unsigned X_W        = cnt_w(H_ACTIVE);
    localparam int unsigned Y_W        = cnt_w(V_ACTIVE);

    state_t             state_q, nxt_state;
    logic [T_W-1:0]     tick_q, nxt_tick;
    logic [L_W-1:0]     line_q, nxt_line;
    logic [1:0]         pat_q, nxt_pat;
    logic [PIX_W-1:0]   color_q, nxt_color;
    logic [FRAME_W-1:0] flat_q, nxt_flat, nxt_frame;
    logic               latch, nxt_href;
    logic [X_W-1:0]     pix_x;
    logic [Y_W-1:0]     pix_y;
    logic [PIX_W-1:0]   pixel;

    function automatic logic [L_W-1:0] last_line(input state_t s);
        case (s)
            ST_VSYNC:  return L_W'(VSYNC_LINES - 1);
            ST_VBP:    return L_W'(VBP_LINES - 1);
            ST_ACTIVE: return L_W'(V_ACTIVE - 1);
            ST_VFP:    return L_W'(VFP_LINES - 1);
            default:   return '0;
        endcase
    endfunction

    // Successor in frame order; IDLE marks the end of the frame.
    function automatic state_t succ(input state_t s);
        case (s)
            ST_VSYNC:  return ST_VBP;
            ST_VBP:    return ST_ACTIVE;
            ST_ACTIVE: return ST_VFP;
            default:   return ST_IDLE;
        endcase
    endfunction

    // Skip forward over regions configured with zero lines.
    function automatic state_t first_from(input state_t s);
        state_t r;
        r = s;
        if (r == ST_VSYNC  && VSYNC_LINES == 0) r = ST_VBP;
        if (r == ST_VBP    && VBP_LINES   == 0) r = ST_ACTIVE;
        if (r == ST_ACTIVE && V_ACTIVE    == 0) r = ST_VFP;
        if (r == ST_VFP    && VFP_LINES   == 0) r = ST_IDLE;
        return r;
    endfunction

    // Position of the byte to be presented after the next tick.
    always_comb begin
        nxt_state = state_q;
        nxt_tick  = tick_q;
        nxt_line  = line_q;
        nxt_frame = frame_cnt_o;
        latch     = 1'b0;
        if (state_q == ST_IDLE) begin
            latch    = enable_i;
            nxt_tick = '0;
            nxt_line = '0;
        end else if (tick_q == T_W'(LINE_TICKS - 1)) begin
            nxt_tick = '0;
            if (line_q == last_line(state_q)) begin
                nxt_line  = '0;
                nxt_state = first_from(succ(state_q));
                if (nxt_state == ST_IDLE) begin
                    nxt_frame = frame_cnt_o + FRAME_W'(1);
                    latch     = enable_i;
                end
            end else begin
                nxt_line = line_q + L_W'(1);
            end
        end else begin
            nxt_tick = tick_q + T_W'(1);
        end
        if (latch) begin
            nxt_state = first_from(ST_VSYNC);
        end
        nxt_pat   = latch ? pattern_sel_i : pat_q;
        nxt_color = latch ? color_i : color_q;
        nxt_flat  = latch ? nxt_frame : flat_q;
        nxt_href  = (nxt_state == ST_ACTIVE) && (32'(nxt_tick) < HREF_TICKS);
    end

    assign pix_x = X_W'(nxt_tick >> 1);
    assign pix_y = Y_W'(nxt_line);

    cam_pixel_pattern #(
        .X_W (X_W),
        .Y_W (Y_W)
    ) u_pattern (
        .x       (pix_x),
        .y       (pix_y),
        .frame   (nxt_flat),
        .pattern (nxt_pat),
        .color   (nxt_color),
        .pixel_c (pixel)
    );

    // Stream state and outputs advance only on tick cycles; de_o is a one-cycle strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            tick_q      <= '0;
            line_q      <= '0;
            pat_q       <= PAT_SOLID;
            color_q     <= '0;
            flat_q      <= '0;
            vsync_o     <= 1'b0;
            href_o      <= 1'b0;
            data_o      <= '0;
            de_o        <= 1'b0;
            frame_cnt_o <= '0;
            busy_o      <= 1'b0;
        end else begin
            de_o <= 1'b0;
            if (tick_i) begin
                state_q     <= nxt_state;
                tick_q      <= nxt_tick;
                line_q      <= nxt_line;
                pat_q       <= nxt_pat;
                color_q     <= nxt_color;
                flat_q      <= nxt_flat;
                frame_cnt_o <= nxt_frame;
                vsync_o     <= (nxt_state == ST_VSYNC);
                href_o      <= nxt_href;
                de_o        <= nxt_href;
                busy_o      <= (nxt_state != ST_IDLE);
                if (!nxt_href) begin
                    data_o <= '0;
                end else if (nxt_tick[0]) begin
                    data_o <= pixel[7:0];
                end else begin
                    data_o <= pixel[15:8];
                end
            end
        end
    end

endmodule

// File: tb/tb_cam_stream_gen.sv
// Directed bench for cam_stream_gen: small geometry (L=10) plus a 16x16 checker instance.
module tb_cam_stream_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        tick_i = 1'b1;
    logic        enable_i = 1'b0;
    logic [1:0]  psel_a = 2'd0;
    logic [1:0]  psel_c = 2'd2;
    logic [15:0] color_i = 16'hF81F;

    logic        vsync_a, href_a, de_a, busy_a;
    logic [7:0]  data_a;
    logic [15:0] frame_a;
    logic        vsync_c, href_c, de_c, busy_c;
    logic [7:0]  data_c;
    logic [15:0] frame_c;

    int errors = 0;
    int checks = 0;
    int pace = 1;
    int phase = 0;

    always #5 clk = ~clk;

    cam_stream_gen #(
        .H_ACTIVE(4), .H_BLANK(2), .V_ACTIVE(3),
        .VSYNC_LINES(1), .VBP_LINES(1), .VFP_LINES(1)
    ) dut (
        .clk(clk), .rst(rst), .tick_i(tick_i), .enable_i(enable_i),
        .pattern_sel_i(psel_a), .color_i(color_i),
        .vsync_o(vsync_a), .href_o(href_a), .data_o(data_a), .de_o(de_a),
        .frame_cnt_o(frame_a), .busy_o(busy_a)
    );

    cam_stream_gen #(
        .H_ACTIVE(16), .H_BLANK(2), .V_ACTIVE(16),
        .VSYNC_LINES(1), .VBP_LINES(1), .VFP_LINES(1)
    ) dut_c (
        .clk(clk), .rst(rst), .tick_i(tick_i), .enable_i(enable_i),
        .pattern_sel_i(psel_c), .color_i(color_i),
        .vsync_o(vsync_c), .href_o(href_c), .data_o(data_c), .de_o(de_c),
        .frame_cnt_o(frame_c), .busy_o(busy_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; sample 1 time unit after the edge, then set tick for the next edge.
    task automatic cyc();
        @(posedge clk);
        #1;
        phase = (phase + 1) % pace;
        tick_i = (phase == 0);
    endtask

    initial begin
        int bad;
        int vs_cnt, de_cnt, k, p, stable_bad;
        logic exp_vs, exp_href, was_tick;
        logic [7:0] exp_byte;
        logic [43:0] snap, prev;

        // Reset and idle
        repeat (3) cyc();
        chk("rst_vsync", 32'(vsync_a), 0);
        chk("rst_href", 32'(href_a), 0);
        chk("rst_data", 32'(data_a), 0);
        chk("rst_frame", 32'(frame_a), 0);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            cyc();
            if ({vsync_a, href_a, de_a, busy_a, data_a, frame_a} != '0) bad++;
        end
        chk("idle_quiet", 32'(bad), 0);
        chk("idle_busy", 32'(busy_a), 0);

        // Full-rate frames: geometry, solid pattern, checker on the wide instance
        enable_i = 1'b1;
        cyc();
        chk("start_vsync", 32'(vsync_a), 1);
        chk("start_busy", 32'(busy_a), 1);
        vs_cnt = 0; de_cnt = 0; k = 0; bad = 0;
        for (int n = 0; n < 360; n++) begin
            if (n < 60) begin
                exp_vs   = (n < 10);
                exp_href = (n >= 20) && (n < 50) && (((n - 20) % 10) < 8);
                vs_cnt += int'(vsync_a);
                de_cnt += int'(de_a);
                if (vsync_a !== exp_vs || href_a !== exp_href || de_a !== exp_href) bad++;
                exp_byte = exp_href ? ((k % 2 == 0) ? 8'hF8 : 8'h1F) : 8'h00;
                if (data_a !== exp_byte) bad++;
                if (exp_href) k++;
            end
            if (n == 30) color_i = 16'h1234;
            if (n == 60) begin
                chk("frame_cnt_60", 32'(frame_a), 1);
                chk("b2b_vsync_60", 32'(vsync_a), 1);
            end
            if (n == 80) chk("next_color_hi", {23'd0, href_a, data_a}, 32'h112);
            if (n == 81) chk("next_color_lo", 32'(data_a), 32'h34);
            if (n == 68) chk("chk_0_0_hi", {23'd0, href_c, data_c}, 32'h100);
            if (n == 84) chk("chk_8_0_hi", {23'd0, href_c, data_c}, 32'h1FF);
            if (n == 85) chk("chk_8_0_lo", {23'd0, href_c, data_c}, 32'h1FF);
            if (n == 340) chk("chk_0_8_hi", {23'd0, href_c, data_c}, 32'h1FF);
            if (n == 356) chk("chk_8_8_hi", {23'd0, href_c, data_c}, 32'h100);
            if (n < 359) cyc();
        end
        chk("vsync_ticks", 32'(vs_cnt), 10);
        chk("de_per_frame", 32'(de_cnt), 24);
        chk("geom_and_bytes", 32'(bad), 0);

        // Enable drop with tick every third cycle
        rst = 1'b1;
        enable_i = 1'b0;
        cyc(); cyc();
        rst = 1'b0;
        pace = 3; phase = 0; tick_i = 1'b1;
        enable_i = 1'b1;
        cyc();
        chk("paced_vsync", 32'(vsync_a), 1);
        p = 0; de_cnt = 0; stable_bad = 0;
        prev = {vsync_a, href_a, busy_a, data_a, frame_a, 8'd0};
        for (int c = 0; c < 200; c++) begin
            was_tick = tick_i;
            cyc();
            snap = {vsync_a, href_a, busy_a, data_a, frame_a, 8'd0};
            if (was_tick) begin
                p++;
                de_cnt += int'(de_a);
            end else if (snap !== prev || de_a !== 1'b0) begin
                stable_bad++;
            end
            prev = snap;
            if (p == 25) enable_i = 1'b0;
        end
        chk("drop_hold_between_ticks", 32'(stable_bad), 0);
        chk("drop_de_count", 32'(de_cnt), 24);
        chk("drop_busy", 32'(busy_a), 0);
        chk("drop_vsync", 32'(vsync_a), 0);
        chk("drop_frame_cnt", 32'(frame_a), 1);

        // March pattern from idle (frame 1), then async reset mid-line
        pace = 1; phase = 0; tick_i = 1'b1;
        psel_a = 2'd3;
        enable_i = 1'b1;
        cyc();
        repeat (46) cyc();
        chk("march_3_2_hi", {23'd0, href_a, data_a}, 32'h100);
        cyc();
        chk("march_3_2_lo", {23'd0, href_a, data_a}, 32'h106);
        #2 rst = 1'b1;
        #1;
        chk("arst_href", 32'(href_a), 0);
        chk("arst_de", 32'(de_a), 0);
        chk("arst_data", 32'(data_a), 0);
        chk("arst_busy", 32'(busy_a), 0);
        chk("arst_frame", 32'(frame_a), 0);
        cyc();
        rst = 1'b0;
        psel_a = 2'd1;
        cyc();
        chk("restart_vsync", 32'(vsync_a), 1);
        chk("restart_frame", 32'(frame_a), 0);
        repeat (46) cyc();
        chk("grad_3_2_hi", 32'(data_a), 32'h18);
        cyc();
        chk("grad_3_2_lo", 32'(data_a), 32'h40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
